// File: rtl/uart_up_master.sv
// Byte-stream command decoder that drives up-bus read/write requests and returns response bytes.
// One transaction at a time; req asserts one cycle after the last frame byte, response follows the ack.
module uart_up_master #(
  parameter int         TIMEOUT  = 1024,
  parameter logic [7:0] ACK_BYTE = 8'hA5,
  parameter logic [7:0] ERR_BYTE = 8'hEE
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        up_rreq,
  input  logic        up_rack,
  output logic [13:0] up_raddr,
  input  logic [31:0] up_rdata,
  output logic        up_wreq,
  input  logic        up_wack,
  output logic [13:0] up_waddr,
  output logic [31:0] up_wdata
);

  localparam int            TW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_REQ, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          is_wr_q, is_wr_d;
  logic [13:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          rreq_q, rreq_d;
  logic          wreq_q, wreq_d;
  logic [TW-1:0] tout_q, tout_d;
  logic [31:0]   resp_q, resp_d;
  logic [2:0]    rcnt_q, rcnt_d;
  logic          tvalid_q, tvalid_d;
  logic          tready_q, tready_d;
  logic          s_acc, m_acc;

  assign s_acc = s_axis_tvalid && tready_q;
  assign m_acc = tvalid_q && m_axis_tready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_wr_d  = is_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rreq_d   = rreq_q;
    wreq_d   = wreq_q;
    tout_d   = tout_q;
    resp_d   = resp_q;
    rcnt_d   = rcnt_q;
    tvalid_d = tvalid_q;
    case (state_q)
      S_IDLE: begin
        if (s_acc) begin
          if (s_axis_tdata == 8'h01 || s_axis_tdata == 8'h02) begin
            is_wr_d = (s_axis_tdata == 8'h01);
            addr_d  = '0;
            wdata_d = '0;
            cnt_d   = '0;
            state_d = S_ADDR;
          end else begin
            resp_d   = {ERR_BYTE, 24'h0};
            rcnt_d   = 3'd1;
            tvalid_d = 1'b1;
            state_d  = S_RESP;
          end
        end
      end
      S_ADDR: begin
        if (s_acc) begin
          // Shifting through 14 bits drops the top two bits of the first address byte.
          addr_d = {addr_q[5:0], s_axis_tdata};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd1) begin
            cnt_d = '0;
            if (is_wr_q) begin
              state_d = S_DATA;
            end else begin
              rreq_d  = 1'b1;
              tout_d  = '0;
              state_d = S_REQ;
            end
          end
        end
      end
      S_DATA: begin
        if (s_acc) begin
          wdata_d = {wdata_q[23:0], s_axis_tdata};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            wreq_d  = 1'b1;
            tout_d  = '0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        // An ack arriving on the timeout edge still completes normally.
        if (wreq_q && up_wack) begin
          wreq_d   = 1'b0;
          resp_d   = {ACK_BYTE, 24'h0};
          rcnt_d   = 3'd1;
          tvalid_d = 1'b1;
          state_d  = S_RESP;
        end else if (rreq_q && up_rack) begin
          rreq_d   = 1'b0;
          resp_d   = up_rdata;
          rcnt_d   = 3'd4;
          tvalid_d = 1'b1;
          state_d  = S_RESP;
        end else if (tout_q == TOUT_LAST) begin
          wreq_d   = 1'b0;
          rreq_d   = 1'b0;
          resp_d   = {ERR_BYTE, 24'h0};
          rcnt_d   = 3'd1;
          tvalid_d = 1'b1;
          state_d  = S_RESP;
        end else begin
          tout_d = tout_q + 1'b1;
        end
      end
      S_RESP: begin
        if (m_acc) begin
          if (rcnt_q == 3'd1) begin
            tvalid_d = 1'b0;
            resp_d   = '0;
            rcnt_d   = '0;
            state_d  = S_IDLE;
          end else begin
            resp_d = {resp_q[23:0], 8'h00};
            rcnt_d = rcnt_q - 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    tready_d = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_DATA);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_wr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rreq_q   <= 1'b0;
      wreq_q   <= 1'b0;
      tout_q   <= '0;
      resp_q   <= '0;
      rcnt_q   <= '0;
      tvalid_q <= 1'b0;
      tready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_wr_q  <= is_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rreq_q   <= rreq_d;
      wreq_q   <= wreq_d;
      tout_q   <= tout_d;
      resp_q   <= resp_d;
      rcnt_q   <= rcnt_d;
      tvalid_q <= tvalid_d;
      tready_q <= tready_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = resp_q[31:24];
  assign up_rreq       = rreq_q;
  assign up_wreq       = wreq_q;
  assign up_raddr      = addr_q;
  assign up_waddr      = addr_q;
  assign up_wdata      = wdata_q;

endmodule

// File: tb/tb_uart_up_master.sv
// Directed plus randomized frames checked against a frame-level reference model and a simple up slave.
module tb_uart_up_master;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        up_rreq;
  logic        up_rack = 1'b0;
  logic [13:0] up_raddr;
  logic [31:0] up_rdata = '0;
  logic        up_wreq;
  logic        up_wack = 1'b0;
  logic [13:0] up_waddr;
  logic [31:0] up_wdata;

  int checks = 0;
  int failures = 0;
  int r;
  logic [7:0] fr [7];
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  uart_up_master #(.TIMEOUT(TO), .ACK_BYTE(8'hA5), .ERR_BYTE(8'hEE)) dut (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .up_rreq(up_rreq), .up_rack(up_rack), .up_raddr(up_raddr), .up_rdata(up_rdata),
    .up_wreq(up_wreq), .up_wack(up_wack), .up_waddr(up_waddr), .up_wdata(up_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctl"}, {28'h0, s_axis_tready, m_axis_tvalid, up_rreq, up_wreq}, 32'h0);
    chk({tag, "_tdata"}, {24'h0, m_axis_tdata}, 32'h0);
    chk({tag, "_addr"}, {4'h0, up_raddr, up_waddr}, 32'h0);
    chk({tag, "_wdata"}, up_wdata, 32'h0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = b;
    while (s_axis_tready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_tready_wait", {31'h0, s_axis_tready}, 32'h1);
    @(posedge clk);
    #1 s_axis_tvalid = 1'b0;
  endtask

  // Reference model: frame bytes -> expected address/data, req duration and response bytes.
  task automatic run_frame(input logic [7:0] f [7], input int d, input logic [31:0] rd,
                           input int bp, input string nm);
    bit is_wr, is_rd, stalled;
    int nb, a, exp_req, rcyc, addr_bad, wrong_req, stall_bad;
    logic [13:0] ea;
    logic [31:0] ed;
    logic [7:0] prev;
    logic [7:0] got [$];
    is_wr = (f[0] == 8'h01);
    is_rd = (f[0] == 8'h02);
    nb = is_wr ? 7 : (is_rd ? 3 : 1);
    a  = (int'(f[1]) % 64) * 256 + int'(f[2]);
    ea = 14'(a);
    ed = {f[3], f[4], f[5], f[6]};
    exp_q.delete();
    if (!is_wr && !is_rd) exp_q.push_back(8'hEE);
    else if (d > TO) exp_q.push_back(8'hEE);
    else if (is_wr) exp_q.push_back(8'hA5);
    else for (int i = 0; i < 4; i++) exp_q.push_back(rd[31-8*i -: 8]);
    exp_req = (is_wr || is_rd) ? ((d > TO) ? TO : d) : 0;

    for (int i = 0; i < nb; i++) send_byte(f[i]);

    rcyc = 0; addr_bad = 0; wrong_req = 0;
    for (int n = 0; n < TO + 40; n++) begin
      @(negedge clk);
      up_wack  = 1'b0;
      up_rack  = 1'b0;
      up_rdata = $urandom;
      if ((is_wr && up_rreq) || (is_rd && up_wreq) || (!is_wr && !is_rd && (up_rreq || up_wreq)))
        wrong_req++;
      if ((is_wr ? up_wreq : up_rreq) !== 1'b1) break;
      rcyc++;
      if (s_axis_tready !== 1'b0) wrong_req++;
      if (is_wr && (up_waddr !== ea || up_wdata !== ed)) addr_bad++;
      if (is_rd && up_raddr !== ea) addr_bad++;
      if (rcyc == d) begin
        if (is_wr) up_wack = 1'b1;
        else begin up_rack = 1'b1; up_rdata = rd; end
      end else begin
        // Pulses on the non-matching ack line must be ignored.
        if (is_wr) up_rack = 1'($urandom);
        else up_wack = 1'($urandom);
      end
    end
    up_wack = 1'b0;
    up_rack = 1'b0;
    chk({nm, "_req_cycles"}, rcyc, exp_req);
    chk({nm, "_addr_data"}, addr_bad, 0);
    chk({nm, "_wrong_req"}, wrong_req, 0);
    chk({nm, "_tvalid_latency"}, {31'h0, m_axis_tvalid}, 32'h1);

    stalled = 1'b0; stall_bad = 0; prev = '0;
    for (int n = 0; n < 200 && got.size() < exp_q.size(); n++) begin
      if (n > 0) @(negedge clk);
      if (stalled && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev)) stall_bad++;
      case (bp)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = 1'(n % 2);
        default: m_axis_tready = 1'($urandom);
      endcase
      if (m_axis_tvalid && m_axis_tready) begin
        got.push_back(m_axis_tdata);
        stalled = 1'b0;
      end else begin
        stalled = m_axis_tvalid;
        prev    = m_axis_tdata;
      end
    end
    @(negedge clk);
    m_axis_tready = 1'b0;
    chk({nm, "_resp_len"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_resp_byte%0d", nm, i), {24'h0, got[i]}, {24'h0, exp_q[i]});
    chk({nm, "_tdata_stable"}, stall_bad, 0);
    chk({nm, "_done_idle"}, {30'h0, m_axis_tvalid, s_axis_tready}, 32'h1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_tready", {31'h0, s_axis_tready}, 32'h1);

    fr = '{8'h01, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'hBE};
    run_frame(fr, 3, 32'h0, 0, "write");

    fr = '{8'h02, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(fr, 2, 32'h12345678, 0, "read");

    fr = '{8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(fr, 1, 32'h0, 0, "badop");
    fr = '{8'h01, 8'h3F, 8'hFF, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame(fr, 1, 32'h0, 0, "after_bad");

    fr = '{8'h02, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(fr, 100, 32'hCAFEF00D, 0, "timeout");
    run_frame(fr, TO, 32'hA1B2C3D4, 0, "ack_at_timeout");
    run_frame(fr, TO + 1, 32'hA1B2C3D4, 0, "ack_after_timeout");

    fr = '{8'h02, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(fr, 4, 32'h89ABCDEF, 1, "backpressure");

    fr = '{8'h01, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 3; i++) send_byte(fr[i]);
    @(negedge clk);
    rstn    = 1'b0;
    up_wack = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    up_wack = 1'b0;
    rstn    = 1'b1;
    @(negedge clk);
    chk("mid_reset_tready", {31'h0, s_axis_tready}, 32'h1);
    fr = '{8'h02, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(fr, 2, 32'h0BADBEEF, 2, "post_reset");

    for (int k = 0; k < 20; k++) begin
      r = $urandom_range(0, 6);
      for (int i = 0; i < 7; i++) fr[i] = 8'($urandom);
      if (r < 3) fr[0] = 8'h01;
      else if (r < 6) fr[0] = 8'h02;
      else if (fr[0] == 8'h01 || fr[0] == 8'h02) fr[0] = 8'h80;
      run_frame(fr, $urandom_range(1, 20), $urandom, $urandom_range(0, 2), $sformatf("rnd%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_up_master.md
Name: uart_up_master

Overview:
- Initiator end of the up register bus: converts a binary command byte stream into up-bus read/write transactions and returns response bytes.
- Receives bytes on an AXI-Stream slave port, which a UART receiver feeds.
- Drives up_rreq/up_raddr and up_wreq/up_waddr/up_wdata into any up slave, for example the UART register block.
- Sends results on an AXI-Stream master port, which feeds a UART transmitter. This gives host debug access to registers over a serial link.

Parameters:
- TIMEOUT, 1024, cycles to wait for up_wack/up_rack before aborting (must be >= 2).
- ACK_BYTE, 8'hA5, response byte for a completed write.
- ERR_BYTE, 8'hEE, response byte for a bad opcode or a timeout.

Ports:
- clk  input  1  clock.
- rstn  input  1  reset, synchronous, active-low.
- s_axis_tdata  input  8  command byte in.
- s_axis_tvalid  input  1  command byte valid.
- s_axis_tready  output  1  block accepts a command byte.
- m_axis_tdata  output  8  response byte out.
- m_axis_tvalid  output  1  response byte valid.
- m_axis_tready  input  1  downstream accepts the response byte.
- up_rreq  output  1  read request.
- up_rack  input  1  read acknowledge, single-cycle pulse.
- up_raddr  output  14  read address.
- up_rdata  input  32  read data, valid when up_rack=1.
- up_wreq  output  1  write request.
- up_wack  input  1  write acknowledge, single-cycle pulse.
- up_waddr  output  14  write address.
- up_wdata  output  32  write data.

Behaviour:
- Frame format, bytes MSB first:
  - Byte 0 is the opcode: 8'h01 = write, 8'h02 = read.
  - Bytes 1-2 are the address. The upper 2 bits of byte 1 are discarded, giving a 14-bit address.
  - For a write only, bytes 3-6 are data[31:24], [23:16], [15:8], [7:0].
- Byte accept: a byte is accepted on a clk edge where s_axis_tvalid && s_axis_tready.
- Response accept: a response byte is consumed on a clk edge where m_axis_tvalid && m_axis_tready.
- Reset (rstn=0 at a clk edge):
  - All outputs go to 0: tready, tvalid, tdata, up_rreq, up_wreq, addresses, up_wdata.
  - State returns to IDLE and the byte and timeout counters clear.
  - Reset mid-frame or mid-request discards the frame and drops any req in the same edge.
- State machine:
  - IDLE, tready=1:
    - Opcode 01 or 02 is latched and the block moves to ADDR.
    - Any other opcode moves to RESP, loaded with 1 byte = ERR_BYTE.
  - ADDR, tready=1:
    - Takes 2 bytes.
    - Then goes to DATA for a write, or REQ for a read.
  - DATA, tready=1:
    - Takes 4 bytes, shifting into up_wdata.
    - Then goes to REQ.
  - REQ, tready=0:
    - On entry, asserts up_wreq or up_rreq the cycle after the last frame byte is accepted.
    - The timeout counter clears on entry.
    - Address and data hold stable while req=1.
    - req stays high until the ack is sampled high; req is 0 on the cycle after the ack.
    - Acks and rdata are ignored when the matching req is 0.
    - A write ack goes to RESP with 1 byte = ACK_BYTE.
    - A read ack captures up_rdata and goes to RESP with 4 bytes, MSB first.
    - If the counter reaches TIMEOUT-1 with no ack, req drops and the block goes to RESP with 1 byte = ERR_BYTE.
    - An ack on the same edge as the timeout wins, and the normal response is sent.
  - RESP, tready=0:
    - m_axis_tvalid=1, and tdata holds stable until accepted.
    - After the last byte is accepted, tvalid=0 and the block returns to IDLE.
    - Backpressure of any length on m_axis_tready is tolerated.
- Minimum latency: last command byte accepted → req high at +1 cycle → ack (earliest +1) → tvalid high the cycle after the ack.
- Only one transaction is outstanding at a time. Command bytes are not accepted outside IDLE/ADDR/DATA.

Test Plan:
- Write: stream 01 00 04 00 00 00 BE; slave acks 3 cycles after req.
  - up_wreq=1, up_waddr=14'h0004 and up_wdata=32'h000000BE held for 3 cycles.
  - Req drops after the ack, then one byte A5 is output.
- Read: stream 02 C0 00; slave returns up_rdata=32'h12345678 with rack.
  - up_raddr=14'h0000, since the upper bits are discarded.
  - Output is 12 34 56 78 in order.
- Bad opcode: stream 7F → one byte EE; no up_rreq/up_wreq asserted; next valid frame works normally.
- Timeout with TIMEOUT=16: read frame, no rack → up_rreq high for exactly 16 cycles, then EE is output.
- Backpressure: read frame with m_axis_tready toggling 0/1 each cycle → the 4 bytes arrive intact and in order, and tdata is stable while tvalid && !tready.
- Reset mid-operation: assert rstn=0 after the address bytes of a write frame → all outputs 0 the next cycle; after release, a fresh 02 00 08 frame completes correctly.
